// File: rtl/reg_dump_if.sv
// Dump stream: one register word per valid/ready handshake.
interface reg_dump_if;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_addr;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_addr,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_addr,
        output dump_ready
    );
endinterface

// File: rtl/reg_dump.sv
// Register-file dumper: reads two registers per fetch and streams them out
// over a valid/ready handshake, accumulating an XOR checksum of accepted words.
module reg_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    reg_dump_if.master  dump,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SEND_A = 3'd2,
        SEND_B = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   hold_a_q, hold_a_d;
    logic [DATA_W-1:0]   hold_b_q, hold_b_d;
    logic [DATA_W-1:0]   csum_q, csum_d;

    logic [IDX_W-1:0]    idx_p1, idx_p2, nxt_p1;

    logic                busy_d, done_d, valid_d;
    logic [DATA_W-1:0]   data_d;
    logic [ADDR_W-1:0]   addr_d, rs1_d, rs2_d;

    // Next-state, datapath updates, and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        csum_d   = csum_q;
        idx_p1   = idx_q + IDX_W'(1);
        idx_p2   = idx_q + IDX_W'(2);

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
                    csum_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                hold_a_d = read_data1;
                hold_b_d = read_data2;
                state_d  = SEND_A;
            end
            SEND_A: begin
                if (dump.dump_ready) begin
                    csum_d  = csum_q ^ hold_a_q;
                    state_d = (idx_p1 <= LAST_IDX) ? SEND_B : DONE;
                end
            end
            SEND_B: begin
                if (dump.dump_ready) begin
                    csum_d  = csum_q ^ hold_b_q;
                    idx_d   = idx_p2;
                    state_d = (idx_p2 <= LAST_IDX) ? FETCH : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so they register in step with it.
        nxt_p1  = idx_d + IDX_W'(1);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        valid_d = 1'b0;
        data_d  = '0;
        addr_d  = '0;
        rs1_d   = '0;
        rs2_d   = '0;

        case (state_d)
            FETCH: begin
                rs1_d = idx_d[ADDR_W-1:0];
                rs2_d = (nxt_p1 > LAST_IDX) ? idx_d[ADDR_W-1:0] : nxt_p1[ADDR_W-1:0];
            end
            SEND_A: begin
                valid_d = 1'b1;
                data_d  = hold_a_d;
                addr_d  = idx_d[ADDR_W-1:0];
            end
            SEND_B: begin
                valid_d = 1'b1;
                data_d  = hold_b_d;
                addr_d  = nxt_p1[ADDR_W-1:0];
            end
            default: begin
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            idx_q           <= FIRST_IDX;
            hold_a_q        <= '0;
            hold_b_q        <= '0;
            csum_q          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            dump.dump_valid <= 1'b0;
            dump.dump_data  <= '0;
            dump.dump_addr  <= '0;
            Rs1             <= '0;
            Rs2             <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            hold_a_q        <= hold_a_d;
            hold_b_q        <= hold_b_d;
            csum_q          <= csum_d;
            busy            <= busy_d;
            done            <= done_d;
            dump.dump_valid <= valid_d;
            dump.dump_data  <= data_d;
            dump.dump_addr  <= addr_d;
            Rs1             <= rs1_d;
            Rs2             <= rs2_d;
        end
    end

    assign checksum = csum_q;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: three parameterisations, table-driven dump runs,
// random backpressure, held start, and reset abort.
module tb_reg_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start [3];
    logic        ready [3];
    logic [4:0]  rs1   [3];
    logic [4:0]  rs2   [3];
    logic [31:0] rd1   [3];
    logic [31:0] rd2   [3];
    logic        busy  [3];
    logic        done  [3];
    logic [31:0] csum  [3];
    logic        valid [3];
    logic [31:0] ddata [3];
    logic [4:0]  daddr [3];

    int first_of [3] = '{0, 3, 31};
    int last_of  [3] = '{31, 7, 31};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    reg_dump_if dif0 ();
    reg_dump_if dif1 ();
    reg_dump_if dif2 ();

    reg_dump u0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .Rs1(rs1[0]), .Rs2(rs2[0]), .read_data1(rd1[0]), .read_data2(rd2[0]),
        .dump(dif0), .busy(busy[0]), .done(done[0]), .checksum(csum[0])
    );

    reg_dump #(.FIRST_REG(3), .LAST_REG(7)) u1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .Rs1(rs1[1]), .Rs2(rs2[1]), .read_data1(rd1[1]), .read_data2(rd2[1]),
        .dump(dif1), .busy(busy[1]), .done(done[1]), .checksum(csum[1])
    );

    reg_dump #(.FIRST_REG(31), .LAST_REG(31)) u2 (
        .clk(clk), .reset(reset), .start(start[2]),
        .Rs1(rs1[2]), .Rs2(rs2[2]), .read_data1(rd1[2]), .read_data2(rd2[2]),
        .dump(dif2), .busy(busy[2]), .done(done[2]), .checksum(csum[2])
    );

    assign dif0.dump_ready = ready[0];
    assign dif1.dump_ready = ready[1];
    assign dif2.dump_ready = ready[2];
    assign valid[0] = dif0.dump_valid;
    assign valid[1] = dif1.dump_valid;
    assign valid[2] = dif2.dump_valid;
    assign ddata[0] = dif0.dump_data;
    assign ddata[1] = dif1.dump_data;
    assign ddata[2] = dif2.dump_data;
    assign daddr[0] = dif0.dump_addr;
    assign daddr[1] = dif1.dump_addr;
    assign daddr[2] = dif2.dump_addr;

    // Register file contents: x[i] = i * 0x11111111.
    function automatic logic [31:0] rf(input logic [4:0] a);
        return 32'(a) * 32'h11111111;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_rf
        assign rd1[g] = rf(rs1[g]);
        assign rd2[g] = rf(rs2[g]);
    end

    // Expected register value, straight from the register-file definition.
    function automatic logic [31:0] model_val(input int i);
        return (i == 0) ? 32'd0 : 32'(i) * 32'h11111111;
    endfunction

    // Observation log, written only by the monitor.
    int          got_n      [3];
    logic [4:0]  got_addr   [3][512];
    logic [31:0] got_data   [3][512];
    int          done_n     [3];
    int          done_last  [3];
    int          done_prev  [3];
    int          stall_cyc  [3];
    int          stall_viol [3];
    bit          pstall     [3];
    logic [31:0] pdata      [3];
    logic [4:0]  paddr      [3];
    bit   [4:0]  max_rs1    [3];
    bit   [4:0]  max_rs2    [3];

    // Monitor: logs accepted words, done pulses, stall stability and fetch addresses.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pstall[k]) begin
                stall_cyc[k]++;
                if (!valid[k] || ddata[k] !== pdata[k] || daddr[k] !== paddr[k])
                    stall_viol[k]++;
            end
            pstall[k] = valid[k] && !ready[k];
            pdata[k]  = ddata[k];
            paddr[k]  = daddr[k];
            if (valid[k] && ready[k] && got_n[k] < 512) begin
                got_addr[k][got_n[k]] = daddr[k];
                got_data[k][got_n[k]] = ddata[k];
                got_n[k]++;
            end
            if (done[k]) begin
                done_n[k]++;
                done_prev[k] = done_last[k];
                done_last[k] = cyc;
            end
            if (busy[k] && !valid[k] && !done[k]) begin
                if (rs1[k] > max_rs1[k]) max_rs1[k] = rs1[k];
                if (rs2[k] > max_rs2[k]) max_rs2[k] = rs2[k];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input int k, input string nm);
        chk({nm, " busy"},  32'(busy[k]),  32'd0);
        chk({nm, " done"},  32'(done[k]),  32'd0);
        chk({nm, " valid"}, 32'(valid[k]), 32'd0);
        chk({nm, " data"},  ddata[k],      32'd0);
        chk({nm, " addr"},  32'(daddr[k]), 32'd0);
        chk({nm, " rs1"},   32'(rs1[k]),   32'd0);
        chk({nm, " rs2"},   32'(rs2[k]),   32'd0);
        chk({nm, " csum"},  csum[k],       32'd0);
    endtask

    // One start pulse, optional random backpressure, then compare against the model.
    task automatic run_dump(input int k, input int stall_pct, input int exp_n,
                            input int exp_lat, input string nm);
        int first, last, base, dbase, sbase, vbase, s, w;
        logic [31:0] x;
        first = first_of[k];
        last  = last_of[k];
        base  = got_n[k];
        dbase = done_n[k];
        sbase = stall_cyc[k];
        vbase = stall_viol[k];
        @(posedge clk); #1;
        start[k] = 1'b1;
        ready[k] = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start[k] = 1'b0;
        w = 0;
        while (done_n[k] == dbase && w < 1000) begin
            ready[k] = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= 32'(stall_pct));
            @(posedge clk); #1;
            w++;
        end
        ready[k] = 1'b1;
        chk({nm, " no timeout"}, 32'(w < 1000), 32'd1);
        chk({nm, " word count"}, 32'(got_n[k] - base), 32'(exp_n));
        chk({nm, " model count"}, 32'(last - first + 1), 32'(exp_n));
        x = '0;
        for (int j = 0; j < exp_n; j++) begin
            x = x ^ model_val(first + j);
            if (base + j < 512) begin
                chk($sformatf("%s addr%0d", nm, j), 32'(got_addr[k][base + j]), 32'(first + j));
                chk($sformatf("%s data%0d", nm, j), got_data[k][base + j], model_val(first + j));
            end
        end
        chk({nm, " checksum"}, csum[k], x);
        if (exp_lat > 0)
            chk({nm, " latency"}, 32'(done_last[k] - s + 1), 32'(exp_lat));
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " one done"}, 32'(done_n[k] - dbase), 32'd1);
        chk({nm, " checksum hold"}, csum[k], x);
        chk({nm, " idle busy"}, 32'(busy[k]), 32'd0);
        if (stall_pct > 0) begin
            chk({nm, " stall seen"}, 32'(stall_cyc[k] - sbase > 0), 32'd1);
            chk({nm, " stall stable"}, 32'(stall_viol[k] - vbase), 32'd0);
        end
    endtask

    typedef struct {
        int k;
        int stall_pct;
        int exp_n;
        int exp_lat;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int base, dbase, w;
        bit found;

        tbl[0] = '{k: 0, stall_pct: 0,  exp_n: 32, exp_lat: 50};
        tbl[1] = '{k: 1, stall_pct: 0,  exp_n: 5,  exp_lat: 10};
        tbl[2] = '{k: 2, stall_pct: 0,  exp_n: 1,  exp_lat: 4};
        tbl[3] = '{k: 0, stall_pct: 45, exp_n: 32, exp_lat: 0};
        tbl[4] = '{k: 1, stall_pct: 60, exp_n: 5,  exp_lat: 0};

        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_zero_outputs(k, $sformatf("reset u%0d", k));
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 5; t++)
            run_dump(tbl[t].k, tbl[t].stall_pct, tbl[t].exp_n, tbl[t].exp_lat,
                     $sformatf("vec%0d", t));

        // Fetch addresses: x7 alone fetches Rs2=7, x31 alone fetches Rs2=31.
        chk("u1 max rs1", 32'(max_rs1[1]), 32'd7);
        chk("u1 max rs2", 32'(max_rs2[1]), 32'd7);
        chk("u2 fetch rs1", 32'(max_rs1[2]), 32'd31);
        chk("u2 fetch rs2", 32'(max_rs2[2]), 32'd31);

        // start held high: back-to-back dumps, each begun from IDLE after done.
        base  = got_n[1];
        dbase = done_n[1];
        @(posedge clk); #1;
        start[1] = 1'b1;
        w = 0;
        while (done_n[1] - dbase < 2 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        start[1] = 1'b0;
        chk("held no timeout", 32'(w < 200), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("held done count", 32'(done_n[1] - dbase), 32'd2);
        chk("held word count", 32'(got_n[1] - base), 32'd10);
        chk("held done gap", 32'(done_last[1] - done_prev[1]), 32'd10);
        for (int j = 0; j < 10; j++)
            chk($sformatf("held addr%0d", j), 32'(got_addr[1][base + j]), 32'(3 + (j % 5)));

        // Reset in SEND_B of x10/x11 aborts the dump.
        base  = got_n[0];
        dbase = done_n[0];
        @(posedge clk); #1;
        start[0] = 1'b1;
        ready[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        found = 1'b0;
        w = 0;
        while (!found && w < 200) begin
            @(posedge clk); #1;
            w++;
            if (valid[0] && daddr[0] == 5'd11) found = 1'b1;
        end
        chk("abort reached x11", 32'(found), 32'd1);
        chk("abort x11 data", ddata[0], model_val(11));
        reset = 1'b0;
        #1;
        chk_zero_outputs(0, "abort");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort no done", 32'(done_n[0] - dbase), 32'd0);
        chk("abort idle", 32'(busy[0]), 32'd0);
        chk("abort words", 32'(got_n[0] - base), 32'd11);
        run_dump(0, 0, 32, 50, "fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
